// File: rtl/lfsr_deser.sv
// Serial-to-parallel collector for the LFSR output stream.
// LSB-first bits are assembled into WIDTH-bit words and queued in a small FIFO drained by ready/valid.
module lfsr_deser #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [BW-1:0]    bit_cnt,
  output logic [CW-1:0]    fifo_count,
  output logic             overflow
);

  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bit_cnt;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             r_overflow;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_accept;
  logic             w_last;
  logic             w_pop;
  logic             w_full;
  logic             w_push;
  logic             w_drop;
  logic [WIDTH-1:0] w_word;

  assign w_accept = in_valid & ~clear;
  assign w_last   = w_accept && (r_bit_cnt == BW'(WIDTH-1));
  assign w_word   = {in_bit, r_shreg[WIDTH-2:0]};
  assign w_pop    = (r_count != '0) && word_ready;
  assign w_full   = (r_count == CW'(DEPTH));
  // A pop on the same edge frees the slot the completed word needs.
  assign w_push   = w_last && (!w_full || w_pop);
  assign w_drop   = w_last && !w_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (clear) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_shreg   <= '0;
        r_bit_cnt <= '0;
      end else begin
        r_shreg[r_bit_cnt] <= in_bit;
        r_bit_cnt          <= r_bit_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_overflow <= 1'b0;
    else if (clear)
      r_overflow <= 1'b0;
    else if (w_drop)
      r_overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && w_push)
      r_mem[r_wr_ptr] <= w_word;
  end

  assign word_valid = (r_count != '0);
  assign word_out   = word_valid ? r_mem[r_rd_ptr] : '0;
  assign bit_cnt    = r_bit_cnt;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_lfsr_deser.sv
// Directed bench for lfsr_deser: hand-computed words, overflow, full+pop, clear and reset cases.
module tb_lfsr_deser;

  logic       clk;
  logic       rst;
  logic       in_bit;
  logic       in_valid;
  logic       clear;
  logic [7:0] word_out;
  logic       word_valid;
  logic       word_ready;
  logic [2:0] bit_cnt;
  logic [2:0] fifo_count;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  lfsr_deser #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .clear      (clear),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .bit_cnt    (bit_cnt),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs set before a step are sampled on that step's rising edge; outputs read 1ns after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    step();
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".word_out"},   32'(word_out),   32'h0);
    chk({tag, ".word_valid"}, 32'(word_valid), 32'h0);
    chk({tag, ".bit_cnt"},    32'(bit_cnt),    32'h0);
    chk({tag, ".fifo_count"}, 32'(fifo_count), 32'h0);
    chk({tag, ".overflow"},   32'(overflow),   32'h0);
  endtask

  task automatic drain(input string tag, input logic [7:0] exp [4]);
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s.word%0d", tag, i), 32'(word_out), 32'(exp[i]));
      step();
    end
    word_ready = 1'b0;
    chk({tag, ".empty_valid"}, 32'(word_valid), 32'h0);
    chk({tag, ".empty_out"},   32'(word_out),   32'h0);
  endtask

  logic [7:0] ovf_exp [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0] sim_exp [4] = '{8'h02, 8'h03, 8'h04, 8'h55};
  logic [7:0] basic_bits = 8'b1010_0101;

  initial begin
    rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; clear = 1'b0; word_ready = 1'b0;
    idle(2);
    rst = 1'b0;
    chk_reset("reset");

    // basic: 1,0,1,0,0,1,0,1 LSB-first = A5
    for (int i = 0; i < 7; i++) send_bit(basic_bits[i]);
    chk("basic.pre_valid", 32'(word_valid), 32'h0);
    chk("basic.bit_cnt7",  32'(bit_cnt),    32'd7);
    send_bit(basic_bits[7]);
    chk("basic.valid", 32'(word_valid), 32'h1);
    chk("basic.word",  32'(word_out),   32'hA5);
    chk("basic.count", 32'(fifo_count), 32'd1);
    chk("basic.bitcnt_wrap", 32'(bit_cnt), 32'd0);
    idle(2);
    chk("basic.stable", 32'(word_out), 32'hA5);
    word_ready = 1'b1; step(); word_ready = 1'b0;
    chk("basic.popped_valid", 32'(word_valid), 32'h0);
    chk("basic.popped_out",   32'(word_out),   32'h0);
    word_ready = 1'b1; step(); word_ready = 1'b0;
    chk("basic.empty_pop_count", 32'(fifo_count), 32'd0);

    // gapped 3C: bits 0,0 | gap | 1,1,1 | gap | 1,0,0
    send_bit(1'b0); send_bit(1'b0);
    idle(3);
    chk("gap.hold2", 32'(bit_cnt), 32'd2);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    idle(3);
    chk("gap.hold5", 32'(bit_cnt), 32'd5);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    chk("gap.word", 32'(word_out), 32'h3C);
    word_ready = 1'b1; step(); word_ready = 1'b0;

    // overflow: 01..04 fill, FF dropped
    send_word(8'h01); send_word(8'h02); send_word(8'h03); send_word(8'h04);
    chk("ovf.count_full", 32'(fifo_count), 32'd4);
    chk("ovf.not_yet",    32'(overflow),   32'h0);
    send_word(8'hFF);
    chk("ovf.count", 32'(fifo_count), 32'd4);
    chk("ovf.flag",  32'(overflow),   32'h1);
    drain("ovf", ovf_exp);
    chk("ovf.sticky", 32'(overflow), 32'h1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("ovf.cleared", 32'(overflow), 32'h0);

    // full + simultaneous pop on completion of 55
    send_word(8'h01); send_word(8'h02); send_word(8'h03); send_word(8'h04);
    for (int i = 0; i < 7; i++) send_bit(i[0] == 1'b0);
    word_ready = 1'b1;
    send_bit(1'b0);
    word_ready = 1'b0;
    chk("sim.overflow", 32'(overflow),   32'h0);
    chk("sim.count",    32'(fifo_count), 32'd4);
    drain("sim", sim_exp);

    // clear mid-word, then 96
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    chk("clr.bit_cnt3", 32'(bit_cnt), 32'd3);
    clear = 1'b1;
    send_bit(1'b1);
    clear = 1'b0;
    chk("clr.bit_cnt0", 32'(bit_cnt), 32'd0);
    chk("clr.no_push",  32'(fifo_count), 32'd0);
    send_word(8'h96);
    chk("clr.word",     32'(word_out), 32'h96);
    chk("clr.overflow", 32'(overflow), 32'h0);
    chk("clr.count",    32'(fifo_count), 32'd1);
    word_ready = 1'b1; step(); word_ready = 1'b0;

    // reset mid-operation
    send_word(8'h11); send_word(8'h22);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("rst.pre_count",  32'(fifo_count), 32'd2);
    chk("rst.pre_bitcnt", 32'(bit_cnt),    32'd5);
    rst = 1'b1; step(); rst = 1'b0;
    chk_reset("rst");
    send_word(8'hC3);
    chk("rst.word",  32'(word_out),   32'hC3);
    chk("rst.count", 32'(fifo_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_deser.md
# lfsr_deser

Serial-to-parallel collector placed directly downstream of the LFSR serial output stage. It captures the LSB-first bit stream (`out` qualified by `valid` from the LFSR) into WIDTH-bit words and queues completed words in a small FIFO. The FIFO is drained by a ready/valid handshake, so checkers or a host interface can read LFSR results as parallel words without tracking individual bit timing.

## Interface
- `WIDTH`, 8, bits per assembled word (must equal the LFSR width)
- `DEPTH`, 4, FIFO entries (power of 2, ≥2)
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  synchronous reset, active-high; one clock, one synchronous active-high reset
- `in_bit`  in  1  serial data bit (LFSR `out`)
- `in_valid`  in  1  `in_bit` is valid this cycle (LFSR `valid`)
- `clear`  in  1  abort partial word, clear `overflow`; FIFO untouched
- `word_out`  out  WIDTH  FIFO head word; 0 when FIFO empty
- `word_valid`  out  1  FIFO non-empty
- `word_ready`  in  1  consumer accepts head word this cycle
- `bit_cnt`  out  clog2(WIDTH)  bits collected into current partial word
- `fifo_count`  out  clog2(DEPTH)+1  occupied FIFO entries
- `overflow`  out  1  sticky: a completed word was dropped because FIFO was full

## Operation
- Bit order: the first accepted bit becomes word bit 0, the k-th accepted bit becomes bit k-1 (LSB-first, matching LFSR shift-out).
- Accept: on an edge with `in_valid`=1 and `clear`=0, `in_bit` is written to `shreg[bit_cnt]`, and `bit_cnt` increments.
- Completion: when `in_valid`=1 and `bit_cnt`==WIDTH-1, the word {in_bit, shreg[WIDTH-2:0]} is pushed, `bit_cnt` wraps to 0, and `shreg` clears to 0.
- Push rule: a push succeeds if `fifo_count`<DEPTH, or if a pop occurs on the same edge (full with simultaneous pop is legal). Otherwise the word is dropped, `overflow` is set, and FIFO contents are unchanged.
- Pop: on an edge with `word_valid`=1 and `word_ready`=1. `word_ready` while empty is ignored.
- Simultaneous push+pop: `fifo_count` is unchanged, and ordering is preserved (the pushed word goes behind the remaining entries).
- `clear` has priority over `in_valid` in the same cycle: `bit_cnt`←0, `shreg`←0, `overflow`←0, and the bit is discarded. Pop still proceeds normally during `clear`.
- `rst` has priority over everything. It empties the FIFO and discards the partial word.
- FIFO pointers are circular mod DEPTH, and the full/empty state is derived from `fifo_count`.
- `in_valid` may be deasserted for any number of cycles mid-word; the partial word is held.

## Timing
- Reset values: `word_out`=0, `word_valid`=0, `bit_cnt`=0, `fifo_count`=0, `overflow`=0, and all pointers are 0.
- Outputs are functions of registered state only; there is no combinational path from inputs to outputs.
- Latency: if the last bit of a word is accepted at edge N, then `word_valid`=1 and `word_out` is valid after edge N (visible in cycle N+1).
- Throughput: one bit per cycle in, one word per cycle out.
- `word_out` is stable while `word_valid`=1 and `word_ready`=0.
- After a pop at edge M, `word_out` shows the next entry (or 0) after edge M.
- `overflow` goes high after the dropping edge and remains high until `clear` or `rst`.

## Test plan
- Basic: after `rst`, stream bits 1,0,1,0,0,1,0,1 with `in_valid`=1 and `word_ready`=0. Required: `word_valid` rises the cycle after the 8th bit, `word_out`=8'hA5, `fifo_count`=1.
- Gapped input: send 8'h3C LSB-first with `in_valid` low for 3 cycles after bits 2 and 5. Required: `bit_cnt` holds during the gaps, final `word_out`=8'h3C.
- Overflow: with `word_ready`=0, send 8'h01, 02, 03, 04, then FF. Required: `fifo_count`=4, `overflow`=1, 8'hFF dropped. Then raise `word_ready` and read 01, 02, 03, 04 on consecutive cycles; `word_valid` drops after the 4th pop.
- Full + simultaneous pop: fill 4 words, then complete 8'h55 on the same edge as a pop. Required: no overflow, `fifo_count` stays 4, drain order 02, 03, 04, 55.
- Clear mid-word: send 3 bits of 8'hFF, assert `clear` together with a 4th `in_valid`, then send 8'h96. Required: `bit_cnt`=0 after clear, `word_out`=8'h96, `overflow`=0.
- Reset mid-operation: with 2 words queued and `bit_cnt`=5, assert `rst` for one cycle. Required: all outputs equal their reset values on the next cycle, and the next 8 bits form word 0 correctly.
